// File: rtl/cnn_fifo_pkg.sv
// Shared FIFO helpers: pointer/count width functions and status-vector bit positions.
package cnn_fifo_pkg;

  localparam int STAT_EMPTY  = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_AEMPTY = 2;
  localparam int STAT_AFULL  = 3;
  localparam int STAT_OVF    = 4;
  localparam int STAT_UDF    = 5;
  localparam int STAT_W      = 6;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo: registered read port by default,
// asynchronous read port when SYNC_FIFO_FWFT_EN is defined. Array is never reset.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic             rst_n,
  input  logic             i_rd_en,
`endif
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rd_data = r_mem[i_rd_addr];
`else
  logic [WIDTH-1:0] r_rd_data;

  // Output register holds the last popped word between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
`endif

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered status, thresholds and sticky error flags; read latency 1
// (0 with SYNC_FIFO_FWFT_EN); writes when full / reads when empty are dropped and flagged.
module sync_fifo
  import cnn_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rest_n,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        data_out_vld,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [fifo_cnt_w(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = fifo_ptr_w(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] LP_AE    = CW'(AE_THRESH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic [STAT_W-1:0] r_stat;
  logic [STAT_W-1:0] w_stat_nxt;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Acceptance uses only registered status, so no wr_en/rd_en -> full/empty path exists.
  assign w_wr_acc = wr_en && !r_stat[STAT_FULL]  && !clr;
  assign w_rd_acc = rd_en && !r_stat[STAT_EMPTY] && !clr;

  always_comb begin
    w_count_nxt = r_count;
    if (clr)                         w_count_nxt = '0;
    else if (w_wr_acc && !w_rd_acc)  w_count_nxt = r_count + CW'(1);
    else if (w_rd_acc && !w_wr_acc)  w_count_nxt = r_count - CW'(1);

    w_stat_nxt              = '0;
    w_stat_nxt[STAT_EMPTY]  = (w_count_nxt == '0);
    w_stat_nxt[STAT_FULL]   = (w_count_nxt == LP_DEPTH);
    w_stat_nxt[STAT_AEMPTY] = (w_count_nxt <= LP_AE);
    w_stat_nxt[STAT_AFULL]  = (w_count_nxt >= LP_AF);
    w_stat_nxt[STAT_OVF]    = !clr && (r_stat[STAT_OVF] || (wr_en && r_stat[STAT_FULL]));
    w_stat_nxt[STAT_UDF]    = !clr && (r_stat[STAT_UDF] || (rd_en && r_stat[STAT_EMPTY]));
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      r_wr_ptr            <= '0;
      r_rd_ptr            <= '0;
      r_count             <= '0;
      r_stat              <= '0;
      r_stat[STAT_EMPTY]  <= 1'b1;
      r_stat[STAT_AEMPTY] <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_stat  <= w_stat_nxt;
      if (clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  assign count        = r_count;
  assign empty        = r_stat[STAT_EMPTY];
  assign full         = r_stat[STAT_FULL];
  assign almost_empty = r_stat[STAT_AEMPTY];
  assign almost_full  = r_stat[STAT_AFULL];
  assign overflow     = r_stat[STAT_OVF];
  assign underflow    = r_stat[STAT_UDF];

`ifdef SYNC_FIFO_FWFT_EN
  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (rd_data)
  );

  assign data_out_vld = !r_stat[STAT_EMPTY];
`else
  logic r_dout_vld;

  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .rst_n     (rest_n),
    .i_rd_en   (w_rd_acc),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) r_dout_vld <= 1'b0;
    else         r_dout_vld <= w_rd_acc;
  end

  assign data_out_vld = r_dout_vld;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (DEPTH=16, WIDTH=8): directed table, corner sequences and a queue-based model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rest_n;
  logic       clr, wr_en, rd_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       data_out_vld, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  sync_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk          (clk),
    .rest_n       (rest_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .data_out_vld (data_out_vld),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: occupancy is simply the queue length.
  bit [7:0]   q[$];
  logic       m_ovf, m_udf, m_dvld;
  logic [7:0] m_rdata;

  typedef struct packed {
    logic       c, w, r;
    logic [7:0] d;
    logic [4:0] e_cnt;
    logic       e_empty, e_ovf, e_udf, e_dvld;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tag, nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_dvld = 0; m_rdata = 8'h00;
  endtask

  task automatic model_step(input logic c, input logic w, input logic r, input logic [7:0] d);
    bit was_full, was_empty;
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_dvld = 0;
    end else begin
      if (w && was_full)  m_ovf = 1;
      if (r && was_empty) m_udf = 1;
      m_dvld = r && !was_empty;
      if (m_dvld) m_rdata = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
  endtask

  task automatic chk_model(input string tag);
    int n;
    n = q.size();
    chk(tag, "count",        32'(count),        32'(n));
    chk(tag, "full",         32'(full),         32'(n == 16));
    chk(tag, "empty",        32'(empty),        32'(n == 0));
    chk(tag, "almost_full",  32'(almost_full),  32'(n >= 14));
    chk(tag, "almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk(tag, "overflow",     32'(overflow),     32'(m_ovf));
    chk(tag, "underflow",    32'(underflow),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, "data_out_vld", 32'(data_out_vld), 32'(n != 0));
    if (n != 0) chk(tag, "rd_data", 32'(rd_data), 32'(q[0]));
`else
    chk(tag, "data_out_vld", 32'(data_out_vld), 32'(m_dvld));
    chk(tag, "rd_data",      32'(rd_data),      32'(m_rdata));
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, "count",        32'(count),        32'd0);
    chk(tag, "empty",        32'(empty),        32'd1);
    chk(tag, "full",         32'(full),         32'd0);
    chk(tag, "almost_empty", 32'(almost_empty), 32'd1);
    chk(tag, "almost_full",  32'(almost_full),  32'd0);
    chk(tag, "data_out_vld", 32'(data_out_vld), 32'd0);
    chk(tag, "overflow",     32'(overflow),     32'd0);
    chk(tag, "underflow",    32'(underflow),    32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk(tag, "rd_data",      32'(rd_data),      32'd0);
`endif
  endtask

  // One clock: drive, step model at the edge, compare 1 time unit later.
  task automatic cycle(input logic c, input logic w, input logic r, input logic [7:0] d);
    clr = c; wr_en = w; rd_en = r; wr_data = d;
    @(posedge clk);
    model_step(c, w, r, d);
    #1;
    clr = 0; wr_en = 0; rd_en = 0;
    chk_model("model");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cnt, iter;
    logic [7:0] wd;

    rest_n = 0; clr = 0; wr_en = 0; rd_en = 0; wr_data = 0;
    model_reset();
    #12;
    chk_reset("reset");
    rest_n = 1;

    //               c  w  r  d      cnt emp ovf udf dvld rdata
    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h44, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
      chk("tbl", "count",     32'(count),     32'(tbl[i].e_cnt));
      chk("tbl", "empty",     32'(empty),     32'(tbl[i].e_empty));
      chk("tbl", "overflow",  32'(overflow),  32'(tbl[i].e_ovf));
      chk("tbl", "underflow", 32'(underflow), 32'(tbl[i].e_udf));
`ifndef SYNC_FIFO_FWFT_EN
      chk("tbl", "data_out_vld", 32'(data_out_vld), 32'(tbl[i].e_dvld));
      chk("tbl", "rd_data",      32'(rd_data),      32'(tbl[i].e_rdata));
`endif
    end

    // Fill to full, then one write too many.
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0, 8'(i));
      chk("fill", "almost_full", 32'(almost_full), 32'((i + 1) >= 14));
    end
    chk("fill", "full",  32'(full),  32'd1);
    chk("fill", "count", 32'(count), 32'd16);
    cycle(0, 1, 0, 8'hEE);
    chk("ovf", "overflow", 32'(overflow), 32'd1);
    chk("ovf", "count",    32'(count),    32'd16);

    // Drain in order; almost_empty once two or fewer remain.
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain", "rd_data", 32'(rd_data), 32'(i));
      cycle(0, 0, 1, 8'h00);
`else
      cycle(0, 0, 1, 8'h00);
      chk("drain", "rd_data", 32'(rd_data), 32'(i));
`endif
      chk("drain", "almost_empty", 32'(almost_empty), 32'((15 - i) <= 2));
    end
    chk("drain", "empty", 32'(empty), 32'd1);

    // Full with simultaneous write and read.
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 8'(8'h80 + i));
`ifdef SYNC_FIFO_FWFT_EN
    chk("full_rw", "rd_data", 32'(rd_data), 32'h80);
    cycle(0, 1, 1, 8'hFF);
`else
    cycle(0, 1, 1, 8'hFF);
    chk("full_rw", "rd_data", 32'(rd_data), 32'h80);
`endif
    chk("full_rw", "count",    32'(count),    32'd15);
    chk("full_rw", "overflow", 32'(overflow), 32'd1);

    // Empty with simultaneous write and read.
    cycle(1, 0, 0, 8'h00);
    cycle(0, 1, 1, 8'h5A);
    chk("empty_rw", "count",     32'(count),     32'd1);
    chk("empty_rw", "underflow", 32'(underflow), 32'd1);

    // Flush at count 5 with a write pending.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'(8'h60 + i));
    chk("clr", "count_before", 32'(count), 32'd5);
    cycle(1, 1, 0, 8'h77);
    chk("clr", "count",     32'(count),     32'd0);
    chk("clr", "empty",     32'(empty),     32'd1);
    chk("clr", "underflow", 32'(underflow), 32'd0);
    chk("clr", "overflow",  32'(overflow),  32'd0);

    // 40 writes interleaved with reads, occupancy held within 3..10.
    wr_cnt = 0; iter = 0; wd = 8'h00;
    while ((wr_cnt < 40 || q.size() > 3) && iter < 400) begin
      int n, sel;
      logic w, r;
      n = q.size();
      sel = $urandom_range(0, 2);
      w = (wr_cnt < 40) && (n < 3 || (n < 10 && sel != 1));
      r = (n > 3) && (n >= 10 || sel != 0 || wr_cnt >= 40);
      cycle(0, w, r, wd);
      if (w) begin wr_cnt++; wd++; end
      iter++;
    end
    chk("interleave", "writes",    32'(wr_cnt),    32'd40);
    chk("interleave", "overflow",  32'(overflow),  32'd0);
    chk("interleave", "underflow", 32'(underflow), 32'd0);

    // Unconstrained random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 8'($urandom));
    end

    // Asynchronous reset in the middle of a burst.
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'(8'hC0 + i));
    #2;
    rest_n = 0;
    #1;
    chk_reset("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rest_n = 1;
    cycle(0, 0, 0, 8'h00);

`ifdef SYNC_FIFO_FWFT_EN
    cycle(0, 1, 0, 8'hA5);
    chk("fwft", "data_out_vld", 32'(data_out_vld), 32'd1);
    chk("fwft", "rd_data",      32'(rd_data),      32'hA5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
